// File: rtl/fpga_link_burst_sender_if.sv
// Link bundle between the burst sender, its upstream word source and FPGA 2.
// master: the sender itself. slave: the environment (process + remote FPGA).
interface fpga_link_burst_sender_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
);
    logic              start;
    logic [CNT_W-1:0]  send_count;
    logic [DATA_W-1:0] data_in;
    logic              data_pop;
    logic              rewind;
    logic              rdy_in;
    logic              ack_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              csum_out;
    logic              req_out;
    logic              send_done;
    logic              done;
    logic              error;

    modport master (
        input  start, send_count, data_in, rdy_in, ack_in,
        output data_pop, rewind, data_out, valid_out, csum_out, req_out,
               send_done, done, error
    );

    modport slave (
        output start, send_count, data_in, rdy_in, ack_in,
        input  data_pop, rewind, data_out, valid_out, csum_out, req_out,
               send_done, done, error
    );
endinterface

// File: rtl/fpga_link_burst_sender.sv
// FPGA-to-FPGA burst transmitter: pops a burst from the local process, streams
// it over the req/rdy/ack link, stretches send_done and waits for ack.
// Handshake timeouts trigger a bounded number of rewinds/replays, then error.
// Optional feature macro LINK_CHECKSUM_EN: appends one XOR checksum beat
// (csum_out=1) after the last data word of every attempt.
module fpga_link_burst_sender #(
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 10,
    parameter int DONE_STRETCH = 3,
    parameter int TIMEOUT      = 1023,
    parameter int MAX_RETRY    = 3
) (
    input logic                      clk,
    input logic                      rst,
    fpga_link_burst_sender_if.master bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int SD_W  = $clog2(DONE_STRETCH + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        SEND       = 3'd2,
        WAIT_ACK   = 3'd3,
        RESEND     = 3'd4
`ifdef LINK_CHECKSUM_EN
        , CSUM     = 3'd5
`endif
    } state_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  timer;
    logic [CNT_W-1:0]  len, remaining;
    logic [RTY_W-1:0]  retry;
    logic [SD_W-1:0]   sd_cnt;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, req_q, done_q, error_q, rewind_q;

    logic pop, done_n, error_n, rewind_n, burst_end;
    logic tmo, wait_st, req_n, accept;

    assign tmo     = (timer == TMR_W'(TIMEOUT));
    assign wait_st = (state == WAIT_READY) || (state == WAIT_ACK);
    assign req_n   = (state_n != IDLE) && (state_n != RESEND);
    assign accept  = (state == IDLE) && bus.start;

    // Next state, upstream pop and the pulse outputs for the next cycle.
    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        done_n    = 1'b0;
        error_n   = 1'b0;
        rewind_n  = 1'b0;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.send_count == '0) done_n  = 1'b1;
                    else                      state_n = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (bus.rdy_in)  state_n = SEND;
                else if (tmo)    state_n = RESEND;
            end
            SEND: begin
                pop = bus.rdy_in && (remaining != '0);
                if ((remaining == '0) || (pop && remaining == CNT_W'(1))) begin
`ifdef LINK_CHECKSUM_EN
                    state_n   = CSUM;
`else
                    state_n   = WAIT_ACK;
                    burst_end = 1'b1;
`endif
                end
            end
`ifdef LINK_CHECKSUM_EN
            CSUM: begin
                if (bus.rdy_in) begin
                    state_n   = WAIT_ACK;
                    burst_end = 1'b1;
                end
            end
`endif
            WAIT_ACK: begin
                // ack wins over a simultaneous rdy drop
                if (bus.ack_in) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (!bus.rdy_in || tmo) begin
                    state_n = RESEND;
                end
            end
            RESEND: begin
                if (retry == RTY_W'(MAX_RETRY)) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                end else begin
                    state_n  = WAIT_READY;
                    rewind_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef LINK_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
    logic              csum_q;
    logic              csum_go;

    assign csum_go = (state == CSUM) && bus.rdy_in;

    // Running XOR of the words of the current attempt; restarts on replay.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            csum_q <= 1'b0;
        end else begin
            csum_q <= csum_go;
            if (accept || rewind_n) acc <= '0;
            else if (pop)           acc <= acc ^ bus.data_in;
        end
    end

    assign bus.csum_out = csum_q;
`else
    assign bus.csum_out = 1'b0;
`endif

    // State, counters and registered link outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            len       <= '0;
            remaining <= '0;
            retry     <= '0;
            sd_cnt    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            rewind_q  <= 1'b0;
        end else begin
            state    <= state_n;
            req_q    <= req_n;
            done_q   <= done_n;
            error_q  <= error_n;
            rewind_q <= rewind_n;
`ifdef LINK_CHECKSUM_EN
            valid_q  <= pop || csum_go;
            if (csum_go) data_q <= acc;
`else
            valid_q  <= pop;
`endif
            if (pop) begin
                data_q    <= bus.data_in;
                remaining <= remaining - 1'b1;
            end
            if (accept) begin
                len       <= bus.send_count;
                remaining <= bus.send_count;
                retry     <= '0;
            end
            if (rewind_n) begin
                retry     <= retry + 1'b1;
                remaining <= len;
            end
            // handshake timer: only runs in the two wait states, saturates
            if (state_n != state)  timer <= '0;
            else if (wait_st && !tmo) timer <= timer + 1'b1;
            // send_done stretch counter, dropped whenever WAIT_ACK is left
            if (burst_end)               sd_cnt <= SD_W'(DONE_STRETCH);
            else if (state_n != WAIT_ACK) sd_cnt <= '0;
            else if (sd_cnt != '0)       sd_cnt <= sd_cnt - 1'b1;
        end
    end

    assign bus.data_pop  = pop;
    assign bus.rewind    = rewind_q;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.req_out   = req_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    // ack (or reset) kills the stretched end-of-burst flag in the same cycle
    assign bus.send_done = (sd_cnt != '0) && !bus.ack_in && !rst;
endmodule

// File: tb/tb_fpga_link_burst_sender.sv
// Self-checking bench for fpga_link_burst_sender: table of burst scenarios,
// randomized bursts, and hand-written reset sequences, all checked against a
// burst-level model (expected beat stream, pulse counts, stretch lengths).
module tb_fpga_link_burst_sender;
    localparam int DW = 32, CW = 10, DS = 3, TO = 15, MR = 3;
`ifdef LINK_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int M_PROMPT = 0, M_RAND = 1, M_FIXED = 2, M_DROP = 3, M_NEVER = 4;

    typedef struct {
        int n; int mode; int ack;
        int att; int rew; int dn; int er; int sd;
        int span; int req; int frun;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpga_link_burst_sender_if #(.DATA_W(DW), .CNT_W(CW)) bif ();

    fpga_link_burst_sender #(
        .DATA_W(DW), .CNT_W(CW), .DONE_STRETCH(DS), .TIMEOUT(TO), .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] words [64];
    int  widx, pops, sd_age, zrun, stall_left, cyc;
    bit  sd_prev, start_now, rst_req;
    int  cur_n, cur_mode, cur_ack;
    logic [DW:0] beats [$];
    int  n_rew, n_sd, n_done, n_err, n_req, run_len, first_run;
    int  pop_bad, sd_ack, done_cyc, first_beat, last_beat;
    logic [7:0]    s_outs;
    logic [DW-1:0] s_data;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear();
        widx = 0; pops = 0; sd_age = -1; zrun = 0; stall_left = 3; cyc = -1;
        sd_prev = 1'b0; beats.delete();
        n_rew = 0; n_sd = 0; n_done = 0; n_err = 0; n_req = 0; run_len = 0;
        first_run = -1; pop_bad = 0; sd_ack = 0; done_cyc = -1;
        first_beat = -1; last_beat = -1;
        for (int i = 0; i < 64; i++) words[i] = $urandom;
    endtask

    // One clock: drive inputs just after the edge, sample outputs 1 ns later.
    task automatic step();
        bit r;
        @(posedge clk); #1;
        cyc++;
        if (sd_age >= 0) sd_age++;
        bif.ack_in = (cur_ack > 0) && (sd_age == cur_ack);
        case (cur_mode)
            M_RAND:  r = (pops >= cur_n) || (zrun >= 4) || ($urandom_range(0, 99) >= 30);
            M_FIXED: begin
                r = !(pops == 2 && stall_left > 0);
                if (!r) stall_left--;
            end
            M_DROP:  r = !sd_prev;
            M_NEVER: r = 1'b0;
            default: r = 1'b1;
        endcase
        zrun = r ? 0 : zrun + 1;
        bif.rdy_in     = r;
        bif.start      = start_now;
        start_now      = 1'b0;
        bif.send_count = CW'(cur_n);
        bif.data_in    = words[widx % 64];
        rst            = rst_req;
        #1;
        s_outs = {bif.req_out, bif.valid_out, bif.csum_out, bif.send_done,
                  bif.done, bif.error, bif.rewind, bif.data_pop};
        s_data = bif.data_out;
        if (bif.valid_out) begin
            beats.push_back({bif.csum_out, bif.data_out});
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
        end
        if (bif.data_pop) begin
            if (!bif.rdy_in) pop_bad++;
            widx++;
            pops++;
        end
        if (bif.rewind) begin
            widx = 0; pops = 0; sd_age = -1; n_rew++;
        end
        if (bif.send_done) begin
            n_sd++;
            if (bif.ack_in) sd_ack++;
            if (sd_age < 0) sd_age = 0;
        end
        sd_prev = bif.send_done;
        if (bif.done) begin n_done++; done_cyc = cyc; end
        if (bif.error) n_err++;
        if (bif.req_out) begin
            n_req++; run_len++;
        end else begin
            if (run_len > 0 && first_run < 0) first_run = run_len;
            run_len = 0;
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [DW:0]   exp_q [$];
        logic [DW-1:0] x;
        int mism;
        clear();
        cur_n = v.n; cur_mode = v.mode; cur_ack = v.ack; start_now = 1'b1;
        step();
        while (n_done == 0 && n_err == 0 && cyc < 400) step();
        chk($sformatf("v%0d_finish", id), longint'(n_done + n_err > 0), 1);
        step();
        step();
        chk($sformatf("v%0d_req_idle", id), longint'(s_outs[7]), 0);
        x = '0;
        for (int i = 0; i < v.n; i++) x ^= words[i];
        for (int a = 0; a < v.att; a++) begin
            for (int i = 0; i < v.n; i++) exp_q.push_back({1'b0, words[i]});
            if (CS != 0) exp_q.push_back({1'b1, x});
        end
        chk($sformatf("v%0d_beats", id), beats.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
            if (beats[i] !== exp_q[i]) mism++;
        chk($sformatf("v%0d_stream_mism", id), mism, 0);
        chk($sformatf("v%0d_rewind", id), n_rew, v.rew);
        chk($sformatf("v%0d_done", id), n_done, v.dn);
        chk($sformatf("v%0d_error", id), n_err, v.er);
        chk($sformatf("v%0d_send_done", id), n_sd, v.sd);
        chk($sformatf("v%0d_pop_no_rdy", id), pop_bad, 0);
        chk($sformatf("v%0d_sd_with_ack", id), sd_ack, 0);
        if (v.span >= 0) chk($sformatf("v%0d_span", id), last_beat - first_beat + 1, v.span + CS);
        if (v.req >= 0)  chk($sformatf("v%0d_req_cyc", id), n_req, v.req);
        if (v.frun >= 0) chk($sformatf("v%0d_req_run", id), first_run, v.frun);
        if (v.n == 0)    chk($sformatf("v%0d_done_lat", id), done_cyc, 1);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t rv;
        tbl[0] = '{4, M_PROMPT, 3, 1, 0, 1, 0, 3,  4, -1, -1};
        tbl[1] = '{0, M_PROMPT, 3, 0, 0, 1, 0, 0, -1,  0, -1};
        tbl[2] = '{8, M_FIXED,  2, 1, 0, 1, 0, 2, 11, -1, -1};
        tbl[3] = '{8, M_DROP,   0, 4, 3, 0, 1, 8, -1, -1, -1};
        tbl[4] = '{3, M_NEVER,  0, 0, 3, 0, 1, 0, -1, 64, 16};
        tbl[5] = '{5, M_PROMPT, 1, 1, 0, 1, 0, 1,  5, -1, -1};
        tbl[6] = '{1, M_PROMPT, 6, 1, 0, 1, 0, 3,  1, -1, -1};
        tbl[7] = '{12, M_RAND,  2, 1, 0, 1, 0, 2, -1, -1, -1};

        rst = 1'b1; rst_req = 1'b1; start_now = 1'b0;
        bif.start = 1'b0; bif.send_count = '0; bif.data_in = '0;
        bif.rdy_in = 1'b0; bif.ack_in = 1'b0;
        cur_n = 0; cur_mode = M_PROMPT; cur_ack = 0;
        clear();
        repeat (3) step();
        chk("reset_outs", longint'(s_outs), 0);
        chk("reset_data", longint'(s_data), 0);
        rst_req = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        for (int k = 0; k < 20; k++) begin
            rv.n = int'($urandom_range(1, 24));
            rv.mode = M_RAND;
            rv.ack = int'($urandom_range(1, 8));
            rv.att = 1; rv.rew = 0; rv.dn = 1; rv.er = 0;
            rv.sd = (rv.ack < DS) ? rv.ack : DS;
            rv.span = -1; rv.req = -1; rv.frun = -1;
            run_vec(100 + k, rv);
        end

        // reset in the middle of the data phase
        clear();
        cur_n = 8; cur_mode = M_PROMPT; cur_ack = 0; start_now = 1'b1;
        step();
        for (int i = 0; i < 30 && pops < 4; i++) step();
        chk("rstA_reached", longint'(pops >= 4), 1);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("rstA_outs", longint'(s_outs), 0);
        chk("rstA_data", longint'(s_data), 0);

        // reset on the second send_done cycle
        clear();
        cur_n = 4; cur_mode = M_PROMPT; cur_ack = 0; start_now = 1'b1;
        step();
        for (int i = 0; i < 40 && sd_age < 0; i++) step();
        chk("rstB_reached", longint'(sd_age >= 0), 1);
        rst_req = 1'b1;
        step();
        chk("rstB_sd_drop", longint'(s_outs[4]), 0);
        rst_req = 1'b0;
        step();
        chk("rstB_outs", longint'(s_outs), 0);
        chk("rstB_data", longint'(s_data), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
